// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences an NxN systolic MAC array through one tile.
// It streams operands k = 0..k_len-1 from the A/B read ports into the array
// edges with a diagonal skew, pulses the accumulator clear, waits for the
// wavefront to flush, then drains the N result rows over valid/ready.
// Ports:
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   start_i, k_len_i               tile start and reduction length (IDLE only)
//   row_mask_i, col_mask_i         active rows/columns, latched with start_i
//   busy_o, done_o                 tile in progress / one-cycle end pulse
//   a_rd_*, b_rd_*                 operand read strobes, addresses, data (1-cycle latency)
//   arr_act_o, arr_wgt_o           skewed west-edge activations / north-edge weights
//   arr_en_o, arr_row_en_o,
//   arr_col_en_o, arr_clr_o        array enables and accumulator clear
//   drain_sel_o, out_valid_o,
//   out_ready_i                    result row drain handshake
// Build option: define ZERO_GATE_EN to also drop a lane's enable while its
// skewed operand is zero.
module systolic_ctrl #(
  parameter int N  = 8,
  parameter int DW = 8,
  parameter int KW = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [KW-1:0]   k_len_i,
  input  logic [N-1:0]    row_mask_i,
  input  logic [N-1:0]    col_mask_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            a_rd_en_o,
  output logic            b_rd_en_o,
  output logic [KW-1:0]   a_rd_addr_o,
  output logic [KW-1:0]   b_rd_addr_o,
  input  logic [N*DW-1:0] a_rd_data_i,
  input  logic [N*DW-1:0] b_rd_data_i,
  output logic [N*DW-1:0] arr_act_o,
  output logic [N*DW-1:0] arr_wgt_o,
  output logic            arr_en_o,
  output logic [N-1:0]    arr_row_en_o,
  output logic [N-1:0]    arr_col_en_o,
  output logic            arr_clr_o,
  output logic [SW-1:0]   drain_sel_o,
  output logic            out_valid_o,
  input  logic            out_ready_i
);
  localparam int FW = $clog2(2 * N);
  typedef enum logic [2:0] {IDLE, FEED, FLUSH, DRAIN, DONE} state_t;
  state_t        state_q;
  logic [KW-1:0] k_len_q, addr_q;
  logic [N-1:0]  row_mask_q, col_mask_q;
  logic [FW-1:0] fcnt_q;
  logic [SW-1:0] sel_q;
  logic          busy_q, done_q, rd_en_q, dv_q, clr_q, en_q, valid_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      k_len_q    <= '0;
      addr_q     <= '0;
      row_mask_q <= '0;
      col_mask_q <= '0;
      fcnt_q     <= '0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      dv_q       <= 1'b0;
      clr_q      <= 1'b0;
      en_q       <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      dv_q  <= rd_en_q;
      // The first FEED cycle is the only one with address 0, so clear lands one cycle later.
      clr_q <= state_q == FEED && addr_q == '0;
      // Enable opens the cycle after clear and closes with the last FLUSH cycle.
      en_q  <= clr_q | (en_q & !(state_q == FLUSH && fcnt_q == FW'(2 * N - 1)));
      case (state_q)
        IDLE: if (start_i) begin
          k_len_q    <= k_len_i;
          row_mask_q <= row_mask_i;
          col_mask_q <= col_mask_i;
          busy_q     <= 1'b1;
          if (k_len_i == '0) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            rd_en_q <= 1'b1;
            state_q <= FEED;
          end
        end
        FEED: if (addr_q == k_len_q - KW'(1)) begin
          rd_en_q <= 1'b0;
          addr_q  <= '0;
          state_q <= FLUSH;
        end else begin
          addr_q <= addr_q + KW'(1);
        end
        FLUSH: if (fcnt_q == FW'(2 * N - 1)) begin
          fcnt_q  <= '0;
          valid_q <= 1'b1;
          state_q <= DRAIN;
        end else begin
          fcnt_q <= fcnt_q + FW'(1);
        end
        DRAIN: if (out_ready_i) begin
          if (sel_q == SW'(N - 1)) begin
            sel_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            sel_q <= sel_q + SW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Lane i: one capture register plus i skew stages, each with its own valid bit.
  genvar i;
  for (i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] ad_q [0:i];
    logic [DW-1:0] bd_q [0:i];
    logic [i:0]    v_q;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int s = 0; s <= i; s++) begin
          ad_q[s] <= '0;
          bd_q[s] <= '0;
        end
        v_q <= '0;
      end else begin
        ad_q[0] <= a_rd_data_i[i*DW +: DW];
        bd_q[0] <= b_rd_data_i[i*DW +: DW];
        v_q[0]  <= dv_q;
        for (int s = 1; s <= i; s++) begin
          ad_q[s] <= ad_q[s-1];
          bd_q[s] <= bd_q[s-1];
          v_q[s]  <= v_q[s-1];
        end
      end
    end
    assign arr_act_o[i*DW +: DW] = v_q[i] ? ad_q[i] : '0;
    assign arr_wgt_o[i*DW +: DW] = v_q[i] ? bd_q[i] : '0;
`ifdef ZERO_GATE_EN
    assign arr_row_en_o[i] = en_q & row_mask_q[i] & |arr_act_o[i*DW +: DW];
    assign arr_col_en_o[i] = en_q & col_mask_q[i] & |arr_wgt_o[i*DW +: DW];
`else
    assign arr_row_en_o[i] = en_q & row_mask_q[i];
    assign arr_col_en_o[i] = en_q & col_mask_q[i];
`endif
  end
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign a_rd_en_o   = rd_en_q;
  assign b_rd_en_o   = rd_en_q;
  assign a_rd_addr_o = addr_q;
  assign b_rd_addr_o = addr_q;
  assign arr_en_o    = en_q;
  assign arr_clr_o   = clr_q;
  assign drain_sel_o = sel_q;
  assign out_valid_o = valid_q;
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: cycle-accurate scoreboard bench for systolic_ctrl.
module tb_systolic_ctrl;
  localparam int N = 8, DW = 8, KW = 8;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic [KW-1:0] k_len = '0;
  logic [N-1:0] row_mask = '0, col_mask = '0;
  logic busy, done, a_rd_en, b_rd_en, arr_en, arr_clr, out_valid;
  logic [KW-1:0] a_rd_addr, b_rd_addr;
  logic [N*DW-1:0] a_rd_data = '0, b_rd_data = '0, arr_act, arr_wgt;
  logic [N-1:0] arr_row_en, arr_col_en;
  logic [2:0] drain_sel;
  logic [DW-1:0] a_mem [0:255][0:N-1];
  logic [DW-1:0] b_mem [0:255][0:N-1];
  int tests = 0, fails = 0;
  int exp_q[$];
  systolic_ctrl #(.N(N), .DW(DW), .KW(KW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .k_len_i(k_len),
    .row_mask_i(row_mask), .col_mask_i(col_mask), .busy_o(busy), .done_o(done),
    .a_rd_en_o(a_rd_en), .b_rd_en_o(b_rd_en), .a_rd_addr_o(a_rd_addr), .b_rd_addr_o(b_rd_addr),
    .a_rd_data_i(a_rd_data), .b_rd_data_i(b_rd_data), .arr_act_o(arr_act), .arr_wgt_o(arr_wgt),
    .arr_en_o(arr_en), .arr_row_en_o(arr_row_en), .arr_col_en_o(arr_col_en), .arr_clr_o(arr_clr),
    .drain_sel_o(drain_sel), .out_valid_o(out_valid), .out_ready_i(out_ready));
  always #5 clk = ~clk;
  // Operand buffers: one-cycle read latency, junk on the bus when not read.
  always @(posedge clk)
    for (int i = 0; i < N; i++) begin
      a_rd_data[i*DW +: DW] <= a_rd_en ? a_mem[a_rd_addr][i] : 8'hA5;
      b_rd_data[i*DW +: DW] <= b_rd_en ? b_mem[b_rd_addr][i] : 8'h5A;
    end
  task automatic fill(input bit zero_row3);
    for (int k = 0; k < 256; k++)
      for (int i = 0; i < N; i++) begin
        a_mem[k][i] = (zero_row3 && i == 3) ? '0 : DW'(16 * i + k + 1);
        b_mem[k][i] = DW'(16 * i + k + 1);
      end
  endtask
  function automatic logic [N*DW-1:0] exp_lanes(input bit is_a, input int c, input int k);
    logic [N*DW-1:0] v = '0;
    for (int i = 0; i < N; i++) begin
      int kk = c - 3 - i;
      if (kk >= 0 && kk < k) v[i*DW +: DW] = is_a ? a_mem[kk][i] : b_mem[kk][i];
    end
    return v;
  endfunction
  task automatic run_tile(input string nm, input int k, input logic [N-1:0] rm, input logic [N-1:0] cm,
                          input int stall_row, input int stall_len, input bit poke);
    int r = 0, stalls = 0, done_c = (k == 0) ? 1 : -1;
    start = 1'b1; k_len = KW'(k); row_mask = rm; col_mask = cm;
    if (k > 0) for (int j = 0; j < N; j++) exp_q.push_back(j);
    @(posedge clk); @(negedge clk);
    start = 1'b0; k_len = KW'($urandom); row_mask = N'($urandom); col_mask = N'($urandom);
    for (int c = 1; c <= k + 3 * N + stall_len + 3; c++) begin
      logic [N*DW-1:0] ea = exp_lanes(1'b1, c, k), ew = exp_lanes(1'b0, c, k);
      bit ev = k > 0 && c >= k + 2 * N + 1 && r < N;
      bit een = k > 0 && c >= 3 && c <= k + 2 * N;
      logic [N-1:0] erow = een ? rm : '0, ecol = een ? cm : '0;
`ifdef ZERO_GATE_EN
      for (int i = 0; i < N; i++) begin
        if (ea[i*DW +: DW] == '0) erow[i] = 1'b0;
        if (ew[i*DW +: DW] == '0) ecol[i] = 1'b0;
      end
`endif
      out_ready = !(ev && r == stall_row && stalls < stall_len);
      if (!out_ready) stalls++;
      start = poke && c >= 5 && c <= 7;
      #1;
      tests++; if ({a_rd_en, b_rd_en} !== {2{c <= k}}) begin fails++; $display("FAIL %s c=%0d rd_en got %b exp %b", nm, c, {a_rd_en, b_rd_en}, {2{c <= k}}); end
      if (c <= k) begin
        tests++; if (a_rd_addr !== KW'(c - 1) || b_rd_addr !== KW'(c - 1)) begin fails++; $display("FAIL %s c=%0d rd_addr got %0d/%0d exp %0d", nm, c, a_rd_addr, b_rd_addr, c - 1); end
      end
      tests++; if (arr_clr !== (k > 0 && c == 2)) begin fails++; $display("FAIL %s c=%0d arr_clr got %b exp %b", nm, c, arr_clr, k > 0 && c == 2); end
      tests++; if (arr_en !== een) begin fails++; $display("FAIL %s c=%0d arr_en got %b exp %b", nm, c, arr_en, een); end
      tests++; if (arr_act !== ea) begin fails++; $display("FAIL %s c=%0d arr_act got %h exp %h", nm, c, arr_act, ea); end
      tests++; if (arr_wgt !== ew) begin fails++; $display("FAIL %s c=%0d arr_wgt got %h exp %h", nm, c, arr_wgt, ew); end
      tests++; if (arr_row_en !== erow || arr_col_en !== ecol) begin fails++; $display("FAIL %s c=%0d row/col_en got %b/%b exp %b/%b", nm, c, arr_row_en, arr_col_en, erow, ecol); end
      tests++; if (out_valid !== ev) begin fails++; $display("FAIL %s c=%0d out_valid got %b exp %b", nm, c, out_valid, ev); end
      if (ev) begin
        tests++; if (drain_sel !== 3'(exp_q[0])) begin fails++; $display("FAIL %s c=%0d drain_sel got %0d exp %0d", nm, c, drain_sel, exp_q[0]); end
        if (out_ready) begin
          void'(exp_q.pop_front());
          if (r == N - 1) done_c = c + 1;
          r++;
        end
      end
      tests++; if (done !== (c == done_c)) begin fails++; $display("FAIL %s c=%0d done got %b exp %b", nm, c, done, c == done_c); end
      tests++; if (busy !== (done_c < 0 || c <= done_c)) begin fails++; $display("FAIL %s c=%0d busy got %b exp %b", nm, c, busy, done_c < 0 || c <= done_c); end
      @(negedge clk);
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL %s rows left got %0d exp 0", nm, exp_q.size()); exp_q.delete(); end
    out_ready = 1'b1; start = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if ({busy, done, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, arr_en, arr_row_en, arr_col_en, arr_clr, drain_sel, out_valid} !== '0) begin fails++; $display("FAIL reset ctl got nonzero exp 0"); end
    tests++; if ({arr_act, arr_wgt} !== '0) begin fails++; $display("FAIL reset lanes got %h exp 0", {arr_act, arr_wgt}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_basic;
    run_tile("basic", 4, '1, '1, -1, 0, 1'b0);
  endtask
  task automatic test_stall;
    run_tile("stall", 4, '1, '1, 2, 3, 1'b0);
  endtask
  task automatic test_zero_k_and_busy_start;
    run_tile("k0", 0, '1, '1, -1, 0, 1'b0);
    run_tile("poke", 3, 8'hA5, 8'h3C, -1, 0, 1'b1);
  endtask
  task automatic test_reset_flush;
    start = 1'b1; k_len = 4; row_mask = '1; col_mask = '1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL flush busy got %b exp 1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    tests++; if ({busy, done, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, arr_en, arr_row_en, arr_col_en, arr_clr, drain_sel, out_valid, arr_act, arr_wgt} !== '0) begin fails++; $display("FAIL midreset outputs got nonzero exp 0"); end
    rst_n = 1'b1;
    @(negedge clk);
    run_tile("after_rst", 4, '1, '1, -1, 0, 1'b0);
  endtask
  task automatic test_zero_row;
    fill(1'b1);
    run_tile("row3_zero", 5, '1, '1, -1, 0, 1'b0);
    fill(1'b0);
  endtask
  task automatic test_kmax;
    run_tile("kmax", 255, 8'h6B, 8'hD2, 7, 2, 1'b0);
  endtask
  initial begin
    fill(1'b0);
    test_reset;
    test_basic;
    test_stall;
    test_zero_k_and_busy_start;
    test_reset_flush;
    test_zero_row;
    test_kmax;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for the 8x8 MAC array: on `start` it streams the K dimension of A (activation columns) and B (weight rows) from two read ports into the array edges with the diagonal skew a systolic wavefront needs. It drives the array enables and accumulator clear, waits for the wavefront to flush, then drains the N result rows through a valid/ready port. It sits between the operand buffers and the `mac_unit` grid, one instance per array.

## Interface
- `N`, 8, array dimension (rows = columns)
- `DW`, 8, signed operand width
- `KW`, 8, width of `k_len` and read addresses
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `start`  in  1  begin a tile; sampled only in IDLE
- `k_len`  in  KW  reduction length; latched with `start`
- `row_mask`  in  N  active rows; latched with `start`
- `col_mask`  in  N  active columns; latched with `start`
- `busy`  out  1  tile in progress
- `done`  out  1  one-cycle pulse at tile end
- `a_rd_en`, `b_rd_en`  out  1  operand read strobes
- `a_rd_addr`, `b_rd_addr`  out  KW  read address k
- `a_rd_data`  in  N*DW  A[0..N-1][k], row i in bits [i*DW +: DW]; valid 1 cycle after `a_rd_en`
- `b_rd_data`  in  N*DW  B[k][0..N-1], col j in bits [j*DW +: DW]; valid 1 cycle after `b_rd_en`
- `arr_act`  out  N*DW  skewed activations, row i to west edge of array row i
- `arr_wgt`  out  N*DW  skewed weights, column j to north edge of column j
- `arr_en`  out  1  global PE enable
- `arr_row_en`, `arr_col_en`  out  N  per-row/column PE enables
- `arr_clr`  out  1  accumulator clear pulse
- `drain_sel`  out  clog2(N)  result row selected for output
- `out_valid`  out  1  selected row valid
- `out_ready`  in  1  downstream accepts row

## Operation
- States: IDLE, FEED, FLUSH, DRAIN, DONE.
- IDLE, `start`=1, `k_len`>0: latch inputs, go to FEED. With `k_len`=0: go to DONE. No reads and no `arr_clr` in that case.
- FEED lasts `k_len` cycles. `a_rd_en`=`b_rd_en`=1. Addresses run 0..`k_len`-1, one per cycle. Then go to FLUSH.
- Skew datapath:
  - Returned data is registered once.
  - Row i of `arr_act` passes i further register stages; column j of `arr_wgt` passes j further stages.
  - Skew stages carry a valid bit. Invalid lanes output 0.
- FLUSH lasts 2N cycles, counted by a dedicated counter, then go to DRAIN.
- DRAIN:
  - `out_valid`=1 and `drain_sel`=r for r = 0..N-1.
  - r advances on each `out_valid`&`out_ready` cycle.
  - Acceptance of row N-1 moves to DONE.
  - `out_ready` low holds r and keeps `out_valid` high.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in every state except IDLE.
- `start` outside IDLE is ignored. Latched `k_len` and masks are stable for the whole tile.
- `arr_row_en` = latched `row_mask` and `arr_col_en` = latched `col_mask` whenever `arr_en`=1; both are 0 otherwise.
- No arithmetic here. Accumulation width (24 bits) lives in the array.

## Timing
- Cycle 0 is the edge where `start` is sampled in IDLE.
- Reads: address k issued in cycle 1+k; data arrives in cycle 2+k.
- `arr_clr`: one pulse in cycle 2.
- A[i][k] appears on `arr_act` row i in cycle 3+k+i. B[k][j] appears on `arr_wgt` column j in cycle 3+k+j.
- `arr_en` is high for cycles 3 through `k_len`+2N inclusive, a window of `k_len`+2(N-1) cycles.
- First `out_valid` is in cycle `k_len`+2N+1. With `out_ready` held high, `done` is in cycle `k_len`+3N+1.
- Reset (`rst_n`=0 at any edge, including mid-tile):
  - Next state is IDLE, all skew registers and counters clear.
  - All outputs are 0: `busy`, `done`, `a_rd_en`, `b_rd_en`, both addresses, `arr_act`, `arr_wgt`, `arr_en`, `arr_row_en`, `arr_col_en`, `arr_clr`, `drain_sel`, `out_valid`.
- `k_len` = 2^KW-1: the address counter must not wrap before FEED exits.

## Configuration
- `ZERO_GATE_EN` defined: per-lane gating on zero operands.
  - `arr_row_en[i]` is additionally cleared in any cycle where row i's skewed activation is 0.
  - `arr_col_en[j]` is additionally cleared in any cycle where column j's skewed weight is 0.
  - Purpose: reduce MAC switching on sparse operands. Timing and results are unchanged.
- Undefined: enables follow the masks only, as in Operation.

## Test plan
- Reset, N=8, `k_len`=4, all-ones masks, `start`, `out_ready`=1 -> reads at cycles 1..4, `arr_clr` in cycle 2, `arr_en` cycles 3..20, `out_valid` cycles 21..28 with `drain_sel` 0..7, `done` in cycle 29.
- A[i][k] = 16*i + k + 1 -> `arr_act` row 5 carries 81, 82, 83, 84 in cycles 8..11 and is 0 elsewhere. Same check applies to `arr_wgt` column 5.
- `out_ready` low for 3 cycles at row 2 -> `drain_sel` holds 2 and `out_valid` stays high; `done` is delayed by 3 cycles.
- `start` with `k_len`=0 -> `done` in cycle 1, no reads, no `arr_clr`. `start` pulsed while busy -> ignored.
- `rst_n` low during FLUSH -> next cycle all outputs 0, state IDLE. A fresh `start` then reproduces the first scenario exactly.
- With `ZERO_GATE_EN`, row 3 of A all zero -> `arr_row_en[3]`=0 throughout and results are unchanged. Without the macro -> `arr_row_en[3]` follows `arr_en`.
